// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART frame controller.
package uart_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CSUM    = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    HUNT,
    LEN,
    PAYLOAD,
    CSUM,
    DRAIN
  } state_t;

endpackage

// File: rtl/uart_rx_frame_ctrl_frame_buffer.sv
// Payload store: register array with a synchronous write port and a
// registered read port, so read data appears one cycle after the address.
module frame_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  // Capture payload bytes; reset wipes any frame that was still buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read; addresses past the end read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else begin
      rdata <= (int'(raddr) < DEPTH) ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// Frame assembler: hunts for SYNC, collects LEN and payload, verifies the
// 8-bit additive checksum and only then streams the payload downstream.
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int         MAX_LEN     = 16,
  parameter int         TIMEOUT_CYC = 50000,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  output logic       rx_en,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       rx_busy,
  output logic [7:0] pl_data,
  output logic       pl_valid,
  input  logic       pl_ready,
  output logic       pl_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int PW = $clog2(MAX_LEN + 1);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYC - 1);

  state_t          state, state_nxt;
  logic [PW-1:0]   len_reg, len_nxt;
  logic [PW-1:0]   wr_ptr, wr_nxt;
  logic [PW-1:0]   rd_ptr, rd_nxt;
  logic [7:0]      csum, csum_nxt;
  logic [CW-1:0]   tmo_cnt, tmo_nxt;
  logic            valid_nxt, ok_nxt, err_nxt;
  logic [1:0]      code_nxt;
  logic            buf_we;
  logic [AW-1:0]   buf_raddr;
  logic            timed;
  logic            unused_rx_busy;

  assign unused_rx_busy = rx_busy;

  assign timed   = (state == LEN) || (state == PAYLOAD) || (state == CSUM);
  assign rx_en   = (state == HUNT) || timed;
  assign busy    = (state != IDLE) && (state != HUNT);
  assign pl_last = pl_valid && (rd_ptr == len_reg - PW'(1));

  frame_buffer #(
    .DEPTH (MAX_LEN),
    .AW    (AW)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (buf_we),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (rx_data),
    .raddr (buf_raddr),
    .rdata (pl_data)
  );

  // Next-state, datapath updates and pulse generation for the frame FSM.
  always_comb begin
    state_nxt = state;
    len_nxt   = len_reg;
    wr_nxt    = wr_ptr;
    rd_nxt    = rd_ptr;
    csum_nxt  = csum;
    tmo_nxt   = '0;
    valid_nxt = 1'b0;
    ok_nxt    = 1'b0;
    err_nxt   = 1'b0;
    code_nxt  = err_code;
    buf_we    = 1'b0;
    buf_raddr = rd_ptr[AW-1:0];

    if (!enable) begin
      state_nxt = IDLE;
      len_nxt   = '0;
      wr_nxt    = '0;
      rd_nxt    = '0;
      csum_nxt  = '0;
    end else begin
      case (state)
        IDLE: state_nxt = HUNT;
        HUNT: begin
          if (rx_done && (rx_data == SYNC_BYTE)) begin
            state_nxt = LEN;
          end
        end
        LEN: begin
          if (rx_done) begin
            if ((rx_data == 8'd0) || (rx_data > MAX_LEN_B)) begin
              err_nxt   = 1'b1;
              code_nxt  = ERR_LEN;
              state_nxt = HUNT;
            end else begin
              len_nxt   = rx_data[PW-1:0];
              csum_nxt  = rx_data;
              wr_nxt    = '0;
              state_nxt = PAYLOAD;
            end
          end
        end
        PAYLOAD: begin
          if (rx_done) begin
            buf_we   = 1'b1;
            csum_nxt = csum + rx_data;
            wr_nxt   = wr_ptr + PW'(1);
            if (wr_ptr == len_reg - PW'(1)) begin
              state_nxt = CSUM;
            end
          end
        end
        CSUM: begin
          if (rx_done) begin
            if (rx_data == csum) begin
              ok_nxt    = 1'b1;
              rd_nxt    = '0;
              state_nxt = DRAIN;
            end else begin
              err_nxt   = 1'b1;
              code_nxt  = ERR_CSUM;
              state_nxt = HUNT;
            end
          end
        end
        DRAIN: begin
          valid_nxt = 1'b1;
          if (pl_valid && pl_ready) begin
            rd_nxt    = rd_ptr + PW'(1);
            buf_raddr = AW'(rd_ptr + PW'(1));
            if (pl_last) begin
              valid_nxt = 1'b0;
              rd_nxt    = '0;
              state_nxt = HUNT;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase

      if (timed && !rx_done) begin
        if (tmo_cnt == TMO_LAST) begin
          err_nxt   = 1'b1;
          code_nxt  = ERR_TIMEOUT;
          state_nxt = HUNT;
        end else begin
          tmo_nxt = tmo_cnt + CW'(1);
        end
      end
    end
  end

  // State, counters, checksum and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      len_reg   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      csum      <= '0;
      tmo_cnt   <= '0;
      pl_valid  <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= ERR_NONE;
    end else begin
      state     <= state_nxt;
      len_reg   <= len_nxt;
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      csum      <= csum_nxt;
      tmo_cnt   <= tmo_nxt;
      pl_valid  <= valid_nxt;
      frame_ok  <= ok_nxt;
      frame_err <= err_nxt;
      err_code  <= code_nxt;
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed and randomized checks of the UART frame controller against a
// frame-level expectation model (checksum computed arithmetically).
module tb_uart_rx_frame_ctrl;
  import uart_pkg::*;

  localparam int MAX_LEN     = 16;
  localparam int TIMEOUT_CYC = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       rx_en;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       rx_busy = 1'b0;
  logic [7:0] pl_data;
  logic       pl_valid;
  logic       pl_ready = 1'b0;
  logic       pl_last;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  int nVec = 0;
  int nMis = 0;
  int okCnt = 0;
  int errCnt = 0;
  int validCnt = 0;
  logic [7:0] rxQ[$];
  logic       lastQ[$];
  logic [7:0] txQ[$];
  logic [1:0] lastErr = ERR_NONE;

  logic       prevStall = 1'b0;
  logic       prevOk = 1'b0;
  logic       prevErr = 1'b0;
  logic       prevLast = 1'b0;
  logic [7:0] prevData = 8'h00;

  int         e0, v0;
  logic [7:0] q[$];
  logic [7:0] cs;
  logic       readyPat[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [7:0] dataPat[5]  = '{8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hBB};
  logic       lastPat[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

  always #5 clk = ~clk;

  uart_rx_frame_ctrl #(
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .rx_en     (rx_en),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .pl_data   (pl_data),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .pl_last   (pl_last),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nMis++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    rx_busy = 1'b1;
    tick();
    rx_done = 1'b0;
    rx_busy = 1'b0;
    rx_data = 8'($urandom);
  endtask

  task automatic applyStimulus(input int maxGap);
    while (txQ.size() > 0) begin
      sendByte(txQ.pop_front());
      if (maxGap > 0) repeat ($urandom_range(0, maxGap)) tick();
    end
  endtask

  function automatic logic [7:0] csumOf(input int len, input logic [7:0] pl[$]);
    int s;
    s = len;
    foreach (pl[i]) s += int'(pl[i]);
    return 8'(s % 256);
  endfunction

  task automatic waitDone(input bit randReady);
    int n;
    n = 0;
    tick();
    while (busy === 1'b1 && n < 400) begin
      pl_ready = randReady ? 1'($urandom % 2) : 1'b1;
      tick();
      n++;
    end
    checkOutput("drain_done", busy, 0);
    pl_ready = 1'b1;
    repeat (2) tick();
  endtask

  task automatic runFrame(input int kind, input bit randReady);
    int len, ok0, err0, expOk, expErr;
    logic [7:0] b;
    logic [7:0] pl[$];
    ok0 = okCnt; err0 = errCnt; expOk = 0; expErr = 0;
    rxQ.delete(); lastQ.delete(); txQ.delete();
    if (kind == 3) begin
      repeat ($urandom_range(1, 3)) begin
        b = 8'($urandom);
        if (b == SYNC_BYTE_DEF) b = 8'h00;
        txQ.push_back(b);
      end
    end
    txQ.push_back(SYNC_BYTE_DEF);
    if (kind == 2) begin
      len = ($urandom % 2 == 0) ? 0 : int'($urandom_range(MAX_LEN + 1, 255));
      txQ.push_back(8'(len));
      expErr = 1;
      lastErr = ERR_LEN;
    end else begin
      len = int'($urandom_range(1, MAX_LEN));
      txQ.push_back(8'(len));
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom);
        pl.push_back(b);
        txQ.push_back(b);
      end
      if (kind == 1) begin
        txQ.push_back(csumOf(len, pl) + 8'($urandom_range(1, 255)));
        expErr = 1;
        lastErr = ERR_CSUM;
        pl.delete();
      end else begin
        txQ.push_back(csumOf(len, pl));
        expOk = 1;
      end
    end
    applyStimulus(3);
    waitDone(randReady);
    checkOutput("rnd_ok_count", okCnt - ok0, expOk);
    checkOutput("rnd_err_count", errCnt - err0, expErr);
    checkOutput("rnd_err_code", err_code, lastErr);
    checkOutput("rnd_pl_count", rxQ.size(), pl.size());
    for (int i = 0; i < pl.size() && i < rxQ.size(); i++) begin
      checkOutput("rnd_pl_data", rxQ[i], pl[i]);
      checkOutput("rnd_pl_last", lastQ[i], (i == pl.size() - 1) ? 1 : 0);
    end
  endtask

  // Output monitor: counts pulses, collects delivered payload and checks
  // the per-cycle stream and pulse rules.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prevStall = 1'b0;
        prevOk = 1'b0;
        prevErr = 1'b0;
      end else begin
        if (frame_ok) okCnt++;
        if (frame_err) errCnt++;
        if (pl_valid) validCnt++;
        if (frame_ok || frame_err) begin
          checkOutput("pulse_rules", {frame_ok & frame_err, (frame_ok & prevOk) | (frame_err & prevErr)}, 0);
        end
        if (pl_valid) checkOutput("rx_en_in_drain", rx_en, 0);
        if (prevStall) checkOutput("stall_hold", {pl_valid, pl_last, pl_data}, {1'b1, prevLast, prevData});
        if (pl_valid && pl_ready) begin
          rxQ.push_back(pl_data);
          lastQ.push_back(pl_last);
        end
        prevStall = pl_valid && !pl_ready;
        prevLast = pl_last;
        prevData = pl_data;
        prevOk = frame_ok;
        prevErr = frame_err;
      end
    end
  end

  // Watchdog so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no completion, required completion before 2 ms");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values
    #2 rst = 1'b1;
    #10;
    checkOutput("rst_rx_en", rx_en, 0);
    checkOutput("rst_pl_valid", pl_valid, 0);
    checkOutput("rst_pl_last", pl_last, 0);
    checkOutput("rst_frame_ok", frame_ok, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    checkOutput("rst_err_code", err_code, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_pl_data", pl_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    enable = 1'b1;
    pl_ready = 1'b1;
    tick();
    checkOutput("hunt_rx_en", rx_en, 1);
    checkOutput("hunt_busy", busy, 0);

    // Good frame A5 03 11 22 33 69
    e0 = errCnt;
    txQ = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
    applyStimulus(0);
    q = '{8'h11, 8'h22, 8'h33};
    sendByte(csumOf(3, q));
    checkOutput("g1_frame_ok", frame_ok, 1);
    checkOutput("g1_busy", busy, 1);
    checkOutput("g1_rx_en", rx_en, 0);
    checkOutput("g1_no_valid_yet", pl_valid, 0);
    tick();
    checkOutput("g1_b0", {pl_valid, pl_last, pl_data}, {1'b1, 1'b0, 8'h11});
    tick();
    checkOutput("g1_b1", {pl_valid, pl_last, pl_data}, {1'b1, 1'b0, 8'h22});
    tick();
    checkOutput("g1_b2", {pl_valid, pl_last, pl_data}, {1'b1, 1'b1, 8'h33});
    tick();
    checkOutput("g1_end_valid", pl_valid, 0);
    checkOutput("g1_end_busy", busy, 0);
    checkOutput("g1_end_rx_en", rx_en, 1);
    checkOutput("g1_no_err", errCnt - e0, 0);

    // Bad checksum, then a good frame
    txQ = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
    applyStimulus(0);
    v0 = validCnt;
    sendByte(8'h6A);
    checkOutput("bc_frame_err", frame_err, 1);
    checkOutput("bc_err_code", err_code, ERR_CSUM);
    checkOutput("bc_frame_ok", frame_ok, 0);
    checkOutput("bc_busy", busy, 0);
    repeat (3) tick();
    checkOutput("bc_no_valid", validCnt - v0, 0);
    lastErr = ERR_CSUM;
    runFrame(0, 0);

    // Noise then zero length; then over-long length
    e0 = errCnt;
    txQ = '{8'h00, 8'hFF, 8'hA5, 8'h00};
    applyStimulus(0);
    checkOutput("bl0_frame_err", frame_err, 1);
    checkOutput("bl0_err_code", err_code, ERR_LEN);
    tick();
    checkOutput("bl0_err_once", errCnt - e0, 1);
    txQ = '{8'hA5, 8'h11};
    applyStimulus(0);
    checkOutput("bl17_frame_err", frame_err, 1);
    checkOutput("bl17_err_code", err_code, ERR_LEN);
    checkOutput("bl17_busy", busy, 0);
    lastErr = ERR_LEN;
    tick();

    // Timeout taken after a silent gap
    txQ = '{8'hA5, 8'h02, 8'h11};
    applyStimulus(0);
    repeat (TIMEOUT_CYC - 1) tick();
    checkOutput("tmo_early_err", frame_err, 0);
    checkOutput("tmo_early_busy", busy, 1);
    tick();
    checkOutput("tmo_err", frame_err, 1);
    checkOutput("tmo_code", err_code, ERR_TIMEOUT);
    checkOutput("tmo_busy", busy, 0);
    checkOutput("tmo_hunt_rx_en", rx_en, 1);
    lastErr = ERR_TIMEOUT;
    tick();

    // Byte on the timeout cycle wins
    e0 = errCnt;
    rxQ.delete(); lastQ.delete();
    txQ = '{8'hA5, 8'h02, 8'h11};
    applyStimulus(0);
    repeat (TIMEOUT_CYC - 1) tick();
    sendByte(8'h22);
    checkOutput("tmo_edge_err", frame_err, 0);
    checkOutput("tmo_edge_busy", busy, 1);
    q = '{8'h11, 8'h22};
    sendByte(csumOf(2, q));
    checkOutput("tmo_edge_ok", frame_ok, 1);
    waitDone(0);
    checkOutput("tmo_edge_no_err", errCnt - e0, 0);
    checkOutput("tmo_edge_count", rxQ.size(), 2);
    checkOutput("tmo_edge_code", err_code, ERR_TIMEOUT);

    // Backpressure with a stray SYNC byte during drain
    rxQ.delete(); lastQ.delete();
    pl_ready = 1'b0;
    txQ = '{8'hA5, 8'h02, 8'hAA, 8'hBB};
    applyStimulus(0);
    q = '{8'hAA, 8'hBB};
    cs = csumOf(2, q);
    sendByte(cs);
    checkOutput("bp_frame_ok", frame_ok, 1);
    tick();
    for (int i = 0; i < 5; i++) begin
      pl_ready = readyPat[i];
      rx_done = (i == 2) ? 1'b1 : 1'b0;
      rx_data = 8'hA5;
      checkOutput("bp_step", {pl_valid, pl_last, pl_data, rx_en}, {1'b1, lastPat[i], dataPat[i], 1'b0});
      tick();
    end
    rx_done = 1'b0;
    checkOutput("bp_end_valid", pl_valid, 0);
    checkOutput("bp_end_busy", busy, 0);
    checkOutput("bp_count", rxQ.size(), 2);
    if (rxQ.size() == 2) begin
      checkOutput("bp_d0", rxQ[0], 8'hAA);
      checkOutput("bp_d1", rxQ[1], 8'hBB);
    end
    pl_ready = 1'b1;
    tick();

    // Asynchronous reset while draining
    pl_ready = 1'b0;
    txQ = '{8'hA5, 8'h01};
    applyStimulus(0);
    q = '{8'h5C};
    sendByte(8'h5C);
    sendByte(csumOf(1, q));
    tick();
    checkOutput("rd_in_drain", pl_valid, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rd_rx_en", rx_en, 0);
    checkOutput("rd_pl_valid", pl_valid, 0);
    checkOutput("rd_pl_last", pl_last, 0);
    checkOutput("rd_frame_ok", frame_ok, 0);
    checkOutput("rd_frame_err", frame_err, 0);
    checkOutput("rd_err_code", err_code, 0);
    checkOutput("rd_busy", busy, 0);
    checkOutput("rd_pl_data", pl_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    pl_ready = 1'b1;
    lastErr = ERR_NONE;
    tick();
    checkOutput("rd_hunt_rx_en", rx_en, 1);

    // Enable drop mid-payload
    e0 = errCnt;
    txQ = '{8'hA5, 8'h04, 8'h11, 8'h22};
    applyStimulus(0);
    checkOutput("en_payload_busy", busy, 1);
    enable = 1'b0;
    tick();
    checkOutput("en_idle_busy", busy, 0);
    checkOutput("en_idle_rx_en", rx_en, 0);
    checkOutput("en_idle_err", frame_err, 0);
    enable = 1'b1;
    tick();
    checkOutput("en_hunt_rx_en", rx_en, 1);
    runFrame(0, 0);
    checkOutput("en_no_err", errCnt - e0, 0);

    // Randomized frames with random backpressure
    for (int k = 0; k < 24; k++) begin
      case ($urandom % 5)
        0, 1:    runFrame(0, 1);
        2:       runFrame(1, 1);
        3:       runFrame(2, 1);
        default: runFrame(3, 1);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
